// File: rtl/core_ldq_wb_if.sv
// Bundle for the load-return queue: load issue, bus response, hazard probe
// and register-file writeback.
//
// Handshake: a load is offered with ld_valid and is accepted on the clock
// edge where ld_valid && (!ldq_full || pop). pop means a response
// (rsp_ack || rsp_err) arrives while the queue holds at least one entry.
// ldq_full acts as not-ready. There is no ready on the response side: every
// response is consumed in the cycle it arrives. The writeback
// (wb_valid/wb_rd/wb_data/wb_err) is a one-cycle pulse with no backpressure.
interface core_ldq_wb_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              ld_valid;
    logic [REG_AW-1:0] ld_rd;
    logic [1:0]        ld_size;
    logic              ld_signed;
    logic [1:0]        ld_addr_lo;
    logic              ldq_full;
    logic              ldq_empty;
    logic              rsp_ack;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic [REG_AW-1:0] hz_rs_a;
    logic [REG_AW-1:0] hz_rs_b;
    logic              hz_stall;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_err;
    logic              ldq_fault;

    modport master (
        output ld_valid, ld_rd, ld_size, ld_signed, ld_addr_lo,
        output rsp_ack, rsp_err, rsp_data, hz_rs_a, hz_rs_b,
        input  ldq_full, ldq_empty, hz_stall,
        input  wb_valid, wb_rd, wb_data, wb_err, ldq_fault
    );

    modport slave (
        input  ld_valid, ld_rd, ld_size, ld_signed, ld_addr_lo,
        input  rsp_ack, rsp_err, rsp_data, hz_rs_a, hz_rs_b,
        output ldq_full, ldq_empty, hz_stall,
        output wb_valid, wb_rd, wb_data, wb_err, ldq_fault
    );
endinterface

// File: rtl/core_ldq_wb.sv
// Load-return queue and writeback stage. It keeps issued loads in order,
// pairs each bus response with the oldest entry, then aligns and extends the
// data into a registered register-file write. It also reports load-use
// hazards so decode can stall.
module core_ldq_wb #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         rst,
    core_ldq_wb_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Queue storage; contents beyond count are don't-care, so no reset.
    logic [REG_AW-1:0] q_rd     [DEPTH];
    logic [1:0]        q_size   [DEPTH];
    logic              q_signed [DEPTH];
    logic [1:0]        q_lo     [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fault_q;
    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_err_q;

    logic              full;
    logic              empty;
    logic              rsp;
    logic              pop;
    logic              push;
    logic              overflow;
    logic              spurious;

    logic [REG_AW-1:0] head_rd;
    logic [1:0]        head_size;
    logic              head_signed;
    logic [1:0]        head_lo;

    logic [7:0]        b8;
    logic [15:0]       h16;
    logic [DATA_W-1:0] ext;
    logic              misalign;
    logic              illegal;
    logic              load_err;

    logic              stall;
    logic [PTR_W-1:0]  idx;

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign rsp         = bus.rsp_ack | bus.rsp_err;
    assign pop         = rsp & ~empty;
    assign push        = bus.ld_valid & (~full | pop);
    assign overflow    = bus.ld_valid & full & ~pop;
    assign spurious    = rsp & empty;

    assign head_rd     = q_rd[rd_ptr];
    assign head_size   = q_size[rd_ptr];
    assign head_signed = q_signed[rd_ptr];
    assign head_lo     = q_lo[rd_ptr];

    // Select the byte lane(s) of the response for the head entry and extend.
    always_comb begin
        b8       = bus.rsp_data[{head_lo, 3'b000} +: 8];
        h16      = bus.rsp_data[{head_lo[1], 4'b0000} +: 16];
        ext      = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (head_size)
            2'd0: ext = head_signed ? {{(DATA_W-8){b8[7]}}, b8}
                                    : {{(DATA_W-8){1'b0}}, b8};
            2'd1: begin
                ext      = head_signed ? {{(DATA_W-16){h16[15]}}, h16}
                                       : {{(DATA_W-16){1'b0}}, h16};
                misalign = head_lo[0];
            end
            2'd2: begin
                ext      = bus.rsp_data;
                misalign = (head_lo != 2'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

    assign load_err = bus.rsp_err | misalign | illegal;

    // Hazard: any live queue entry or the writeback in flight targets a source.
    always_comb begin
        stall = 1'b0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (k < int'(count) && q_rd[idx] != '0 &&
                (q_rd[idx] == bus.hz_rs_a || q_rd[idx] == bus.hz_rs_b))
                stall = 1'b1;
        end
        if (wb_valid_q && wb_rd_q != '0 &&
            (wb_rd_q == bus.hz_rs_a || wb_rd_q == bus.hz_rs_b))
            stall = 1'b1;
    end

    // Write the accepted load into the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]     <= bus.ld_rd;
            q_size[wr_ptr]   <= bus.ld_size;
            q_signed[wr_ptr] <= bus.ld_signed;
            q_lo[wr_ptr]     <= bus.ld_addr_lo;
        end
    end

    // Pointers, occupancy, sticky fault and the registered writeback stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fault_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (overflow || spurious) fault_q <= 1'b1;
            wb_valid_q <= pop & (load_err | (head_rd != '0));
            wb_err_q   <= pop & load_err;
            wb_rd_q    <= pop ? head_rd : '0;
            wb_data_q  <= (pop && !load_err) ? ext : '0;
        end
    end

    assign bus.ldq_full  = full;
    assign bus.ldq_empty = empty;
    assign bus.hz_stall  = stall;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_err    = wb_err_q;
    assign bus.ldq_fault = fault_q;
endmodule

// File: tb/tb_core_ldq_wb.sv
// Bench for core_ldq_wb: a table of single-load vectors plus hand-written
// sequences for full-queue, overflow, hazard and reset corner cases.
module tb_core_ldq_wb;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [4:0] exp_q[$];

    core_ldq_wb_if #(.DATA_W(32), .REG_AW(5)) bus ();

    core_ldq_wb #(.DEPTH(4), .DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lo;
        logic        ack;
        logic        err;
        logic [31:0] data;
        logic        exp_valid;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[15];

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [1:0] size,
                              input logic sgn, input logic [1:0] lo);
        bus.ld_valid   = 1'b1;
        bus.ld_rd      = rd;
        bus.ld_size    = size;
        bus.ld_signed  = sgn;
        bus.ld_addr_lo = lo;
    endtask

    task automatic idle();
        bus.ld_valid = 1'b0;
        bus.rsp_ack  = 1'b0;
        bus.rsp_err  = 1'b0;
    endtask

    // Word ack carrying a tag of the expected head rd, so the writeback data is checkable.
    task automatic ack_head();
        bus.rsp_ack  = 1'b1;
        bus.rsp_data = 32'hA000_0000 | {27'd0, exp_q[0]};
    endtask

    task automatic check_wb_from_q(input string tag);
        logic [4:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, {31'd0, bus.wb_valid}, 32'd1);
            check({tag, "_rd"}, {27'd0, bus.wb_rd}, {27'd0, e});
            check({tag, "_data"}, bus.wb_data, 32'hA000_0000 | {27'd0, e});
            check({tag, "_err"}, {31'd0, bus.wb_err}, 32'd0);
        end
    endtask

    task automatic do_reset();
        idle();
        bus.hz_rs_a = '0;
        bus.hz_rs_b = '0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_rd      = '0;
        bus.ld_size    = '0;
        bus.ld_signed  = 1'b0;
        bus.ld_addr_lo = '0;
        bus.rsp_ack    = 1'b0;
        bus.rsp_err    = 1'b0;
        bus.rsp_data   = '0;
        bus.hz_rs_a    = '0;
        bus.hz_rs_b    = '0;

        //            rd  sz sg lo ack err data          v  rd  exp_data      e  name
        vecs[0]  = '{5'd3,  2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 32'h0080_FF00, 1'b1, 5'd3,  32'hFFFF_FF80, 1'b0, "byte_s_lo2"};
        vecs[1]  = '{5'd4,  2'd1, 1'b0, 2'd2, 1'b1, 1'b0, 32'hBEEF_1234, 1'b1, 5'd4,  32'h0000_BEEF, 1'b0, "half_u_lo2"};
        vecs[2]  = '{5'd5,  2'd2, 1'b0, 2'd1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 5'd5,  32'h0000_0000, 1'b1, "word_misalign"};
        vecs[3]  = '{5'd6,  2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h1234_56F0, 1'b1, 5'd6,  32'h0000_00F0, 1'b0, "byte_u_lo0"};
        vecs[4]  = '{5'd7,  2'd1, 1'b1, 2'd0, 1'b1, 1'b0, 32'h0000_8001, 1'b1, 5'd7,  32'hFFFF_8001, 1'b0, "half_s_lo0"};
        vecs[5]  = '{5'd8,  2'd2, 1'b1, 2'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 5'd8,  32'hDEAD_BEEF, 1'b0, "word"};
        vecs[6]  = '{5'd9,  2'd1, 1'b0, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 5'd9,  32'h0000_0000, 1'b1, "half_misalign"};
        vecs[7]  = '{5'd10, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0, 32'h1111_1111, 1'b1, 5'd10, 32'h0000_0000, 1'b1, "size3"};
        vecs[8]  = '{5'd11, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 32'h2222_2222, 1'b1, 5'd11, 32'h0000_0000, 1'b1, "bus_err"};
        vecs[9]  = '{5'd12, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 32'h0000_00AA, 1'b1, 5'd12, 32'h0000_0000, 1'b1, "ack_and_err"};
        vecs[10] = '{5'd0,  2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 5'd0,  32'h0000_0000, 1'b0, "rd0_ok"};
        vecs[11] = '{5'd0,  2'd2, 1'b0, 2'd3, 1'b1, 1'b0, 32'h5555_5555, 1'b1, 5'd0,  32'h0000_0000, 1'b1, "rd0_err"};
        vecs[12] = '{5'd31, 2'd0, 1'b1, 2'd3, 1'b1, 1'b0, 32'h7F00_0000, 1'b1, 5'd31, 32'h0000_007F, 1'b0, "byte_s_lo3"};
        vecs[13] = '{5'd13, 2'd1, 1'b1, 2'd2, 1'b1, 1'b0, 32'h8000_7FFF, 1'b1, 5'd13, 32'hFFFF_8000, 1'b0, "half_s_lo2"};
        vecs[14] = '{5'd14, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0, 32'h0000_9A00, 1'b1, 5'd14, 32'hFFFF_FF9A, 1'b0, "byte_s_lo1"};

        // Reset state, sampled while reset is held
        step();
        step();
        check("rst_empty", {31'd0, bus.ldq_empty}, 32'd1);
        check("rst_full",  {31'd0, bus.ldq_full},  32'd0);
        check("rst_stall", {31'd0, bus.hz_stall},  32'd0);
        check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("rst_wb_err", {31'd0, bus.wb_err}, 32'd0);
        check("rst_fault", {31'd0, bus.ldq_fault}, 32'd0);
        check("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        rst = 1'b1;
        step();

        // Single-load vectors: issue, respond next cycle, check writeback after one edge
        for (int i = 0; i < 15; i++) begin
            drive_load(vecs[i].rd, vecs[i].size, vecs[i].sgn, vecs[i].lo);
            step();
            bus.ld_valid = 1'b0;
            check({vecs[i].name, "_not_empty"}, {31'd0, bus.ldq_empty}, 32'd0);
            bus.rsp_ack  = vecs[i].ack;
            bus.rsp_err  = vecs[i].err;
            bus.rsp_data = vecs[i].data;
            step();
            idle();
            check({vecs[i].name, "_valid"}, {31'd0, bus.wb_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check({vecs[i].name, "_rd"}, {27'd0, bus.wb_rd}, {27'd0, vecs[i].exp_rd});
                check({vecs[i].name, "_data"}, bus.wb_data, vecs[i].exp_data);
                check({vecs[i].name, "_err"}, {31'd0, bus.wb_err}, {31'd0, vecs[i].exp_err});
            end
            check({vecs[i].name, "_empty"}, {31'd0, bus.ldq_empty}, 32'd1);
            step();
            check({vecs[i].name, "_pulse"}, {31'd0, bus.wb_valid}, 32'd0);
        end
        check("table_fault", {31'd0, bus.ldq_fault}, 32'd0);

        // Fill to DEPTH, then push+pop at full; order must be preserved
        exp_q.delete();
        for (int i = 1; i <= 4; i++) begin
            drive_load(5'(i), 2'd2, 1'b0, 2'd0);
            exp_q.push_back(5'(i));
            step();
        end
        check("fill_full", {31'd0, bus.ldq_full}, 32'd1);
        ack_head();
        drive_load(5'd5, 2'd2, 1'b0, 2'd0);
        exp_q.push_back(5'd5);
        step();
        bus.ld_valid = 1'b0;
        check_wb_from_q("full_pushpop");
        check("full_stays", {31'd0, bus.ldq_full}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            ack_head();
            step();
            check_wb_from_q("drain");
        end
        idle();
        step();
        check("drain_empty", {31'd0, bus.ldq_empty}, 32'd1);
        check("drain_fault", {31'd0, bus.ldq_fault}, 32'd0);

        // Overflow drops the entry; ack on empty is spurious
        for (int i = 1; i <= 4; i++) begin
            drive_load(5'(i), 2'd2, 1'b0, 2'd0);
            exp_q.push_back(5'(i));
            step();
        end
        drive_load(5'd9, 2'd2, 1'b0, 2'd0);
        step();
        bus.ld_valid = 1'b0;
        check("ovf_fault", {31'd0, bus.ldq_fault}, 32'd1);
        check("ovf_full", {31'd0, bus.ldq_full}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            ack_head();
            step();
            check_wb_from_q("ovf_drain");
        end
        check("ovf_q_used", exp_q.size(), 32'd0);
        bus.rsp_ack  = 1'b1;
        bus.rsp_data = 32'h1234_5678;
        step();
        idle();
        check("spur_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        check("spur_fault", {31'd0, bus.ldq_fault}, 32'd1);
        check("spur_empty", {31'd0, bus.ldq_empty}, 32'd1);
        step();

        // Load-use hazard
        bus.hz_rs_a = 5'd7;
        drive_load(5'd7, 2'd2, 1'b0, 2'd0);
        step();
        bus.ld_valid = 1'b0;
        check("hz_pending", {31'd0, bus.hz_stall}, 32'd1);
        step();
        check("hz_hold", {31'd0, bus.hz_stall}, 32'd1);
        bus.rsp_ack  = 1'b1;
        bus.rsp_data = 32'h0;
        step();
        idle();
        check("hz_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("hz_wb_cycle", {31'd0, bus.hz_stall}, 32'd1);
        step();
        check("hz_clear", {31'd0, bus.hz_stall}, 32'd0);
        bus.hz_rs_a = 5'd5;
        bus.hz_rs_b = 5'd0;
        drive_load(5'd0, 2'd2, 1'b0, 2'd0);
        step();
        bus.ld_valid = 1'b0;
        check("hz_rd0", {31'd0, bus.hz_stall}, 32'd0);
        bus.hz_rs_b = 5'd9;
        drive_load(5'd9, 2'd2, 1'b0, 2'd0);
        step();
        bus.ld_valid = 1'b0;
        check("hz_rs_b", {31'd0, bus.hz_stall}, 32'd1);
        bus.rsp_ack = 1'b1;
        step();
        step();
        idle();
        bus.hz_rs_a = '0;
        bus.hz_rs_b = '0;
        step();
        check("hz_drained", {31'd0, bus.ldq_empty}, 32'd1);

        // Reset mid-stream clears outputs asynchronously; late ack is spurious
        do_reset();
        check("rst2_fault", {31'd0, bus.ldq_fault}, 32'd0);
        drive_load(5'd3, 2'd2, 1'b0, 2'd0);
        step();
        drive_load(5'd4, 2'd2, 1'b0, 2'd0);
        step();
        bus.ld_valid = 1'b0;
        bus.rsp_ack  = 1'b1;
        bus.rsp_data = 32'h0000_0033;
        step();
        idle();
        bus.hz_rs_a = 5'd4;
        check("pre_rst_wb", {31'd0, bus.wb_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("async_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        check("async_empty", {31'd0, bus.ldq_empty}, 32'd1);
        check("async_stall", {31'd0, bus.hz_stall}, 32'd0);
        step();
        rst = 1'b1;
        step();
        bus.rsp_ack = 1'b1;
        step();
        idle();
        check("late_ack_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        check("late_ack_fault", {31'd0, bus.ldq_fault}, 32'd1);
        check("late_ack_empty", {31'd0, bus.ldq_empty}, 32'd1);
        bus.hz_rs_a = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
